// File: rtl/dmem_req_ctrl.sv
// dmem_req_ctrl
//   Data-memory request controller between the MEM stage and the dmem bus.
//   Accepts one load or store from the MEM stage at a time and issues it as a
//   single valid/ready bus request. It holds the pipeline until the response
//   returns and converts bus errors and response timeouts into access-fault
//   traps.
// Ports
//   CLK, RST_N                     clock (rising edge), async active-low reset
//   REQ_VALID/WE/ADDR/WMASK/WDATA  MEM-stage request (mask/data from store_unit)
//   FLUSH                          abandon the current request
//   STALL                          hold the MEM stage
//   RSP_VALID/RDATA/TRAP_VALID/TRAP_MCAUSE  one-cycle completion report
//   DMEM_REQ_VALID/READY, DMEM_ADDR/WE/WMASK/WDATA  bus request channel
//   DMEM_RSP_VALID/RDATA/ERR       bus response channel
module dmem_req_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        REQ_VALID,
  input  logic        REQ_WE,
  input  logic [31:0] REQ_ADDR,
  input  logic [3:0]  REQ_WMASK,
  input  logic [31:0] REQ_WDATA,
  input  logic        FLUSH,
  output logic        STALL,
  output logic        RSP_VALID,
  output logic [31:0] RSP_RDATA,
  output logic        RSP_TRAP_VALID,
  output logic [30:0] RSP_TRAP_MCAUSE,
  output logic        DMEM_REQ_VALID,
  input  logic        DMEM_REQ_READY,
  output logic [31:0] DMEM_ADDR,
  output logic        DMEM_WE,
  output logic [3:0]  DMEM_WMASK,
  output logic [31:0] DMEM_WDATA,
  input  logic        DMEM_RSP_VALID,
  input  logic [31:0] DMEM_RSP_RDATA,
  input  logic        DMEM_RSP_ERR
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT_CYCLES);

  localparam logic [30:0] TRAP_CODE_LOAD_ACCESS_FAULT  = 31'd5;
  localparam logic [30:0] TRAP_CODE_STORE_ACCESS_FAULT = 31'd7;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic          we_q, we_d;
  logic [3:0]    wmask_q, wmask_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          rsp_trap_q, rsp_trap_d;
  logic [30:0]   rsp_mcause_q, rsp_mcause_d;

  logic          idle_accept;
  logic [CW-1:0] cnt_inc;
  logic [30:0]   fault_code;
  logic          unused_addr_lsb;

  // Byte offset is not needed on the word-addressed bus.
  assign unused_addr_lsb = ^REQ_ADDR[1:0];

  // A store with an empty mask is misaligned; store_unit raises that trap itself.
  assign idle_accept = (state_q == ST_IDLE) & REQ_VALID & ~FLUSH &
                       ~(REQ_WE & (REQ_WMASK == 4'h0));

  assign cnt_inc    = (cnt_q == CNT_LIMIT) ? cnt_q : cnt_q + CW'(1);
  assign fault_code = we_q ? TRAP_CODE_STORE_ACCESS_FAULT : TRAP_CODE_LOAD_ACCESS_FAULT;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wmask_d      = wmask_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = '0;
    rsp_trap_d   = 1'b0;
    rsp_mcause_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (idle_accept) begin
          addr_d  = {REQ_ADDR[31:2], 2'b00};
          we_d    = REQ_WE;
          wmask_d = REQ_WE ? REQ_WMASK : 4'h0;
          wdata_d = REQ_WE ? REQ_WDATA : 32'h0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (DMEM_REQ_READY) begin
          cnt_d   = '0;
          // Flushed in the accept cycle: the bus still owes a response, so drain it.
          state_d = FLUSH ? ST_DRAIN : ST_WAIT;
        end else if (FLUSH) begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_inc;
        if (FLUSH) begin
          state_d = DMEM_RSP_VALID ? ST_IDLE : ST_DRAIN;
        end else if (DMEM_RSP_VALID) begin
          state_d      = ST_IDLE;
          rsp_valid_d  = 1'b1;
          rsp_rdata_d  = we_q ? 32'h0 : DMEM_RSP_RDATA;
          rsp_trap_d   = DMEM_RSP_ERR;
          rsp_mcause_d = DMEM_RSP_ERR ? fault_code : '0;
        end else if (cnt_inc == CNT_LIMIT) begin
          state_d      = ST_DRAIN;
          rsp_valid_d  = 1'b1;
          rsp_trap_d   = 1'b1;
          rsp_mcause_d = fault_code;
        end
      end
      ST_DRAIN: begin
        if (DMEM_RSP_VALID) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wmask_q      <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_trap_q   <= 1'b0;
      rsp_mcause_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wmask_q      <= wmask_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_trap_q   <= rsp_trap_d;
      rsp_mcause_q <= rsp_mcause_d;
    end
  end

  assign STALL           = (state_q == ST_REQ) | (state_q == ST_WAIT) | idle_accept;
  assign RSP_VALID       = rsp_valid_q;
  assign RSP_RDATA       = rsp_rdata_q;
  assign RSP_TRAP_VALID  = rsp_trap_q;
  assign RSP_TRAP_MCAUSE = rsp_mcause_q;
  assign DMEM_REQ_VALID  = (state_q == ST_REQ);
  assign DMEM_ADDR       = addr_q;
  assign DMEM_WE         = we_q;
  assign DMEM_WMASK      = wmask_q;
  assign DMEM_WDATA      = wdata_q;

endmodule

// File: tb/tb_dmem_req_ctrl.sv
// tb_dmem_req_ctrl
//   Self-checking bench for dmem_req_ctrl with a short response timeout.
//   Expected completions are queued when a request is issued and checked by
//   the response monitor whenever RSP_VALID pulses.
module tb_dmem_req_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [3:0]  req_wmask = '0;
  logic [31:0] req_wdata = '0;
  logic        flush = 1'b0;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_trap_valid;
  logic [30:0] rsp_trap_mcause;
  logic        dmem_req_valid;
  logic        dmem_req_ready = 1'b0;
  logic [31:0] dmem_addr;
  logic        dmem_we;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic        dmem_rsp_valid = 1'b0;
  logic [31:0] dmem_rsp_rdata = '0;
  logic        dmem_rsp_err = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        trap;
    logic [30:0] mcause;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  dmem_req_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .CLK(clk), .RST_N(rst_n),
    .REQ_VALID(req_valid), .REQ_WE(req_we), .REQ_ADDR(req_addr),
    .REQ_WMASK(req_wmask), .REQ_WDATA(req_wdata), .FLUSH(flush),
    .STALL(stall), .RSP_VALID(rsp_valid), .RSP_RDATA(rsp_rdata),
    .RSP_TRAP_VALID(rsp_trap_valid), .RSP_TRAP_MCAUSE(rsp_trap_mcause),
    .DMEM_REQ_VALID(dmem_req_valid), .DMEM_REQ_READY(dmem_req_ready),
    .DMEM_ADDR(dmem_addr), .DMEM_WE(dmem_we), .DMEM_WMASK(dmem_wmask),
    .DMEM_WDATA(dmem_wdata), .DMEM_RSP_VALID(dmem_rsp_valid),
    .DMEM_RSP_RDATA(dmem_rsp_rdata), .DMEM_RSP_ERR(dmem_rsp_err)
  );

  always #5 clk = ~clk;

  // Response monitor: every RSP_VALID pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_unexpected: RSP_VALID=1 rdata=%h trap=%b, no response expected",
                 rsp_rdata, rsp_trap_valid);
      end else begin
        mon_e = sb.pop_front();
        n_checks++;
        if (rsp_rdata !== mon_e.rdata) begin
          n_fail++;
          $display("FAIL rsp_rdata: got %h expected %h", rsp_rdata, mon_e.rdata);
        end
        n_checks++;
        if (rsp_trap_valid !== mon_e.trap) begin
          n_fail++;
          $display("FAIL rsp_trap_valid: got %b expected %b", rsp_trap_valid, mon_e.trap);
        end
        n_checks++;
        if (rsp_trap_mcause !== mon_e.mcause) begin
          n_fail++;
          $display("FAIL rsp_mcause: got %h expected %h", rsp_trap_mcause, mon_e.mcause);
        end
      end
    end
  end

  task cyc;
    @(posedge clk);
    #1;
  endtask

  task drive_req(input logic we, input logic [31:0] addr, input logic [3:0] mask,
                 input logic [31:0] data);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wmask = mask;
    req_wdata = data;
  endtask

  task clear_req;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wmask = '0;
    req_wdata = '0;
  endtask

  task test_reset;
    @(negedge clk);
    n_checks++;
    if ({stall, rsp_valid, rsp_rdata, rsp_trap_valid, rsp_trap_mcause} !== '0) begin
      n_fail++;
      $display("FAIL reset_rsp: stall=%b rsp_valid=%b rdata=%h trap=%b mcause=%h, expected all 0",
               stall, rsp_valid, rsp_rdata, rsp_trap_valid, rsp_trap_mcause);
    end
    n_checks++;
    if ({dmem_req_valid, dmem_addr, dmem_we, dmem_wmask, dmem_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_bus: valid=%b addr=%h we=%b mask=%h wdata=%h, expected all 0",
               dmem_req_valid, dmem_addr, dmem_we, dmem_wmask, dmem_wdata);
    end
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task test_store;
    drive_req(1'b1, 32'h0000_1000, 4'hf, 32'hDEAD_BEEF);
    dmem_req_ready = 1'b1;
    sb.push_back('{32'h0, 1'b0, 31'd0});
    @(negedge clk);
    n_checks++;
    if ({stall, dmem_req_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL sw_t0: stall=%b req_valid=%b expected 1 0", stall, dmem_req_valid);
    end
    cyc();
    clear_req();
    @(negedge clk);
    n_checks++;
    if ({dmem_req_valid, dmem_we, dmem_wmask, dmem_addr, dmem_wdata, stall} !==
        {1'b1, 1'b1, 4'hf, 32'h0000_1000, 32'hDEAD_BEEF, 1'b1}) begin
      n_fail++;
      $display("FAIL sw_beat: valid=%b we=%b mask=%h addr=%h wdata=%h stall=%b expected 1 1 f 00001000 deadbeef 1",
               dmem_req_valid, dmem_we, dmem_wmask, dmem_addr, dmem_wdata, stall);
    end
    cyc();
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b1;
    dmem_rsp_rdata = 32'hAAAA_5555;
    @(negedge clk);
    n_checks++;
    if ({stall, dmem_req_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL sw_t2: stall=%b req_valid=%b expected 1 0", stall, dmem_req_valid);
    end
    cyc();
    dmem_rsp_valid = 1'b0;
    dmem_rsp_rdata = '0;
    @(negedge clk);
    n_checks++;
    if ({stall, rsp_valid} !== 2'b01) begin
      n_fail++;
      $display("FAIL sw_t3: stall=%b rsp_valid=%b expected 0 1", stall, rsp_valid);
    end
    cyc();
  endtask

  task test_load_backpressure;
    drive_req(1'b0, 32'h0000_2006, 4'h3, 32'hFFFF_FFFF);
    dmem_req_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b1) begin
      n_fail++;
      $display("FAIL lw_t0_stall: got %b expected 1", stall);
    end
    cyc();
    clear_req();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) dmem_req_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({dmem_req_valid, dmem_addr, dmem_we, dmem_wmask, dmem_wdata, stall} !==
          {1'b1, 32'h0000_2004, 1'b0, 4'h0, 32'h0, 1'b1}) begin
        n_fail++;
        $display("FAIL lw_hold[%0d]: valid=%b addr=%h we=%b mask=%h wdata=%h stall=%b expected 1 00002004 0 0 0 1",
                 i, dmem_req_valid, dmem_addr, dmem_we, dmem_wmask, dmem_wdata, stall);
      end
      cyc();
    end
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b1;
    dmem_rsp_rdata = 32'h1234_5678;
    sb.push_back('{32'h1234_5678, 1'b0, 31'd0});
    @(negedge clk);
    n_checks++;
    if (dmem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL lw_wait_valid: got %b expected 0", dmem_req_valid);
    end
    cyc();
    dmem_rsp_valid = 1'b0;
    dmem_rsp_rdata = '0;
    @(negedge clk);
    n_checks++;
    if ({stall, rsp_valid} !== 2'b01) begin
      n_fail++;
      $display("FAIL lw_rsp: stall=%b rsp_valid=%b expected 0 1", stall, rsp_valid);
    end
    cyc();
  endtask

  task test_store_mask0;
    drive_req(1'b1, 32'h0000_4000, 4'h0, 32'h1111_1111);
    dmem_req_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL mask0_stall: got %b expected 0", stall);
    end
    cyc();
    clear_req();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if ({dmem_req_valid, stall, rsp_valid} !== 3'b000) begin
        n_fail++;
        $display("FAIL mask0_idle[%0d]: valid=%b stall=%b rsp_valid=%b expected 0 0 0",
                 i, dmem_req_valid, stall, rsp_valid);
      end
      cyc();
    end
    dmem_req_ready = 1'b0;
  endtask

  task test_bus_error;
    for (int k = 0; k < 2; k++) begin
      drive_req(k[0], 32'h0000_5008, 4'hc, 32'h1234_0000);
      dmem_req_ready = 1'b1;
      sb.push_back('{32'h0, 1'b1, (k == 0) ? 31'd5 : 31'd7});
      cyc();
      clear_req();
      cyc();
      dmem_req_ready = 1'b0;
      dmem_rsp_valid = 1'b1;
      dmem_rsp_err   = 1'b1;
      dmem_rsp_rdata = (k == 0) ? 32'h0 : 32'h0000_0099;
      cyc();
      dmem_rsp_valid = 1'b0;
      dmem_rsp_err   = 1'b0;
      dmem_rsp_rdata = '0;
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL err_rsp[%0d]: rsp_valid=%b expected 1", k, rsp_valid);
      end
      cyc();
    end
  endtask

  task test_timeout;
    drive_req(1'b0, 32'h0000_6000, 4'h0, 32'h0);
    dmem_req_ready = 1'b1;
    sb.push_back('{32'h0, 1'b1, 31'd5});
    cyc();
    clear_req();
    cyc();
    dmem_req_ready = 1'b0;
    // Four WAIT cycles without a response; the fault reports in the next cycle.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if ({stall, rsp_valid, dmem_req_valid} !== 3'b100) begin
        n_fail++;
        $display("FAIL to_wait[%0d]: stall=%b rsp_valid=%b req_valid=%b expected 1 0 0",
                 i, stall, rsp_valid, dmem_req_valid);
      end
      cyc();
    end
    @(negedge clk);
    n_checks++;
    if ({stall, rsp_valid} !== 2'b01) begin
      n_fail++;
      $display("FAIL to_fire: stall=%b rsp_valid=%b expected 0 1", stall, rsp_valid);
    end
    cyc();
    dmem_rsp_valid = 1'b1;
    dmem_rsp_rdata = 32'h0000_0055;
    drive_req(1'b0, 32'h0000_7000, 4'h0, 32'h0);
    @(negedge clk);
    n_checks++;
    if ({stall, rsp_valid, dmem_req_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL to_drain: stall=%b rsp_valid=%b req_valid=%b expected 0 0 0",
               stall, rsp_valid, dmem_req_valid);
    end
    cyc();
    clear_req();
    dmem_rsp_valid = 1'b0;
    dmem_rsp_rdata = '0;
    @(negedge clk);
    n_checks++;
    if ({stall, rsp_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL to_late_swallowed: stall=%b rsp_valid=%b expected 0 0", stall, rsp_valid);
    end
    cyc();
    drive_req(1'b0, 32'h0000_7000, 4'h0, 32'h0);
    dmem_req_ready = 1'b1;
    sb.push_back('{32'h0BAD_F00D, 1'b0, 31'd0});
    cyc();
    clear_req();
    @(negedge clk);
    n_checks++;
    if ({dmem_req_valid, dmem_addr} !== {1'b1, 32'h0000_7000}) begin
      n_fail++;
      $display("FAIL to_next_beat: valid=%b addr=%h expected 1 00007000", dmem_req_valid, dmem_addr);
    end
    cyc();
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b1;
    dmem_rsp_rdata = 32'h0BAD_F00D;
    cyc();
    dmem_rsp_valid = 1'b0;
    dmem_rsp_rdata = '0;
    cyc();
  endtask

  task test_flush;
    // Flush while the request is still on the bus.
    drive_req(1'b0, 32'h0000_8000, 4'h0, 32'h0);
    dmem_req_ready = 1'b0;
    cyc();
    clear_req();
    flush = 1'b1;
    @(negedge clk);
    n_checks++;
    if (dmem_req_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL fl_req_valid: got %b expected 1", dmem_req_valid);
    end
    cyc();
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if ({dmem_req_valid, stall, rsp_valid} !== 3'b000) begin
        n_fail++;
        $display("FAIL fl_req_drop[%0d]: valid=%b stall=%b rsp_valid=%b expected 0 0 0",
                 i, dmem_req_valid, stall, rsp_valid);
      end
      cyc();
    end
    // Flush while waiting for the response; the response is then drained.
    drive_req(1'b0, 32'h0000_8004, 4'h0, 32'h0);
    dmem_req_ready = 1'b1;
    cyc();
    clear_req();
    cyc();
    dmem_req_ready = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b1) begin
      n_fail++;
      $display("FAIL fl_wait_stall: got %b expected 1", stall);
    end
    cyc();
    flush = 1'b0;
    dmem_rsp_valid = 1'b1;
    dmem_rsp_rdata = 32'h0000_0077;
    @(negedge clk);
    n_checks++;
    if ({stall, rsp_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL fl_drain: stall=%b rsp_valid=%b expected 0 0", stall, rsp_valid);
    end
    cyc();
    dmem_rsp_valid = 1'b0;
    dmem_rsp_rdata = '0;
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fl_drain_done: rsp_valid=%b expected 0", rsp_valid);
    end
    cyc();
    // Response in the same cycle as the flush: back to IDLE directly.
    drive_req(1'b0, 32'h0000_8008, 4'h0, 32'h0);
    dmem_req_ready = 1'b1;
    cyc();
    clear_req();
    cyc();
    dmem_req_ready = 1'b0;
    flush = 1'b1;
    dmem_rsp_valid = 1'b1;
    dmem_rsp_rdata = 32'h0000_0088;
    cyc();
    flush = 1'b0;
    dmem_rsp_valid = 1'b0;
    dmem_rsp_rdata = '0;
    drive_req(1'b0, 32'h0000_9000, 4'h0, 32'h0);
    dmem_req_ready = 1'b1;
    sb.push_back('{32'h3141_5926, 1'b0, 31'd0});
    @(negedge clk);
    n_checks++;
    if ({stall, rsp_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL fl_same_cycle: stall=%b rsp_valid=%b expected 1 0", stall, rsp_valid);
    end
    cyc();
    clear_req();
    cyc();
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b1;
    dmem_rsp_rdata = 32'h3141_5926;
    cyc();
    dmem_rsp_valid = 1'b0;
    dmem_rsp_rdata = '0;
    cyc();
  endtask

  task test_reset_mid;
    drive_req(1'b1, 32'h0000_A004, 4'h3, 32'h0000_BEEF);
    dmem_req_ready = 1'b0;
    cyc();
    clear_req();
    @(negedge clk);
    n_checks++;
    if ({dmem_req_valid, dmem_addr} !== {1'b1, 32'h0000_A004}) begin
      n_fail++;
      $display("FAIL rst_pre: valid=%b addr=%h expected 1 0000a004", dmem_req_valid, dmem_addr);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({stall, rsp_valid, dmem_req_valid, dmem_addr, dmem_we, dmem_wmask, dmem_wdata} !== '0) begin
      n_fail++;
      $display("FAIL rst_async: stall=%b rsp_valid=%b valid=%b addr=%h we=%b mask=%h wdata=%h expected all 0",
               stall, rsp_valid, dmem_req_valid, dmem_addr, dmem_we, dmem_wmask, dmem_wdata);
    end
    cyc();
    rst_n = 1'b1;
    dmem_rsp_valid = 1'b1;
    dmem_rsp_rdata = 32'h0000_00EE;
    cyc();
    dmem_rsp_valid = 1'b0;
    dmem_rsp_rdata = '0;
    @(negedge clk);
    n_checks++;
    if ({stall, rsp_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_stale_rsp: stall=%b rsp_valid=%b expected 0 0", stall, rsp_valid);
    end
    cyc();
  endtask

  initial begin
    test_reset();
    test_store();
    test_load_backpressure();
    test_store_mask0();
    test_bus_error();
    test_timeout();
    test_flush();
    test_reset_mid();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drained: %0d responses outstanding, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
